hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage scalar/vector processor (IF, ID, EX, MEM, WB); the pipeline has no operand forwarding.
- Keeps a 3-entry scoreboard of in-flight destination registers, scalar and vector, for the EX, MEM and WB stages.
- Stalls fetch/decode on read-after-write hazards against those entries.
- Gates taken branches and flushes the branch shadow.

---
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sequencing controller for a 5-stage (IF/ID/EX/MEM/WB) scalar+vector
// pipeline with no operand forwarding. A 3-entry scoreboard tracks in-flight scalar
// and vector destinations in EX/MEM/WB. Fetch/decode is stalled on RAW hazards,
// taken branches are gated, and the branch shadow is flushed.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter bit          WB_BYPASS     = 1'b0,
  parameter bit          X0_HARDWIRED  = 1'b1,
  parameter int unsigned BRANCH_SHADOW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_vs1,
  input  logic [4:0]  id_vs2,
  input  logic        id_vs1_used,
  input  logic        id_vs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  input  logic [4:0]  id_vd,
  input  logic        id_vd_we,
  input  logic        id_branch,
  output logic        stall_fetch,
  output logic        bubble_ex,
  output logic        flush_decode,
  output logic        pc_load,
  output logic [1:0]  pending
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef struct packed {
    logic       valid;
    logic       s_we;
    logic [4:0] s_reg;
    logic       v_we;
    logic [4:0] v_reg;
  } sb_entry_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;
  // With write-through register files the WB writer is already visible to ID.
  localparam int N_CMP = WB_BYPASS ? 2 : 3;
  localparam logic [1:0] SHADOW_INIT = 2'(BRANCH_SHADOW);

  sb_entry_t [2:0] sb_q, sb_d;
  logic [1:0]      shadow_q, shadow_d;
  logic            hazard;
  logic            issue;
  logic            shadow_idle;

  // Scalar source hit; x0 never matches when it is hardwired.
  function automatic logic s_hit(input logic [4:0] rs, input logic used,
                                 input logic [4:0] rd);
    return used && (rs == rd) && !(X0_HARDWIRED && (rs == 5'd0));
  endfunction

  // RAW compare of the decode sources against the compared scoreboard stages.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hazard = 1'b0;
    for (int i = 0; i < N_CMP; i++) begin
      if (sb_q[i].valid) begin
        if (sb_q[i].s_we &&
            (s_hit(id_rs1, id_rs1_used, sb_q[i].s_reg) ||
             s_hit(id_rs2, id_rs2_used, sb_q[i].s_reg)))
          hazard = 1'b1;
        if (sb_q[i].v_we &&
            ((id_vs1_used && (id_vs1 == sb_q[i].v_reg)) ||
             (id_vs2_used && (id_vs2 == sb_q[i].v_reg))))
          hazard = 1'b1;
      end
    end
  end

  // Issue decision and pipeline control outputs; all forced low while rst is high.
  always_comb begin
    shadow_idle  = (shadow_q == 2'd0);
    issue        = !rst && id_valid && !hazard && shadow_idle;
    stall_fetch  = !rst && id_valid && hazard && shadow_idle;
    bubble_ex    = !rst && !issue;
    pc_load      = issue && id_branch;
    flush_decode = !rst && !shadow_idle;
    pending      = rst ? 2'd0
                       : ({1'b0, sb_q[EX].valid} + {1'b0, sb_q[MEM].valid} +
                          {1'b0, sb_q[WB].valid});
  end

  // Scoreboard shift (runs through stalls) and branch shadow countdown.
  always_comb begin
    sb_d      = '0;
    sb_d[WB]  = sb_q[MEM];
    sb_d[MEM] = sb_q[EX];
    if (issue) begin
      sb_d[EX] = '{valid: 1'b1,
                   s_we:  id_rd_we && !(X0_HARDWIRED && (id_rd == 5'd0)),
                   s_reg: id_rd,
                   v_we:  id_vd_we,
                   v_reg: id_vd};
    end
    shadow_d = shadow_q;
    if (pc_load)
      shadow_d = SHADOW_INIT;
    else if (!shadow_idle)
      shadow_d = shadow_q - 2'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      sb_q     <= '0;
      shadow_q <= 2'd0;
    end else begin
      sb_q     <= sb_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters for stall and flush cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_fetch && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
    if (flush_decode && (perf_flush_q != '1))
      perf_flush_d = perf_flush_q + 32'd1;
  end

  // Counter registers, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Two instances share the decode
// inputs: u_dut uses default parameters, u_byp uses WB_BYPASS=1.
// Inputs change on the falling edge and outputs are sampled 1 time unit later.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_vs1, id_vs2, id_rd, id_vd;
  logic       id_rs1_used, id_rs2_used, id_vs1_used, id_vs2_used;
  logic       id_rd_we, id_vd_we, id_branch;

  logic       stall_fetch, bubble_ex, flush_decode, pc_load;
  logic [1:0] pending;
  logic       b_stall_fetch, b_bubble_ex, b_flush_decode, b_pc_load;
  logic [1:0] b_pending;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  logic [31:0] b_perf_stall_cnt, b_perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_vs1(id_vs1), .id_vs2(id_vs2), .id_vs1_used(id_vs1_used), .id_vs2_used(id_vs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_vd(id_vd), .id_vd_we(id_vd_we),
    .id_branch(id_branch),
    .stall_fetch(stall_fetch), .bubble_ex(bubble_ex), .flush_decode(flush_decode),
    .pc_load(pc_load), .pending(pending)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  hazard_ctrl #(.WB_BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_vs1(id_vs1), .id_vs2(id_vs2), .id_vs1_used(id_vs1_used), .id_vs2_used(id_vs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_vd(id_vd), .id_vd_we(id_vd_we),
    .id_branch(id_branch),
    .stall_fetch(b_stall_fetch), .bubble_ex(b_bubble_ex), .flush_decode(b_flush_decode),
    .pc_load(b_pc_load), .pending(b_pending)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(b_perf_stall_cnt), .perf_flush_cnt(b_perf_flush_cnt)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  // Advance to the next falling edge and clear all decode inputs (rst untouched).
  task automatic next_cycle();
    @(negedge clk);
    id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_vs1 = '0; id_vs2 = '0; id_rd = '0; id_vd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_vs1_used = 1'b0; id_vs2_used = 1'b0;
    id_rd_we = 1'b0; id_vd_we = 1'b0; id_branch = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_vs1 = '0; id_vs2 = '0; id_rd = '0; id_vd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_vs1_used = 1'b0; id_vs2_used = 1'b0;
    id_rd_we = 1'b0; id_vd_we = 1'b0; id_branch = 1'b0;

    // Reset: outputs low while rst is high, even with a valid branch presented.
    next_cycle();
    rst = 1'b1; id_valid = 1'b1; id_rd = 5'd5; id_rd_we = 1'b1; id_branch = 1'b1;
    #1;
    chk1("rst_stall", stall_fetch, 1'b0);
    chk1("rst_bubble", bubble_ex, 1'b0);
    chk1("rst_pc_load", pc_load, 1'b0);
    chk1("rst_flush", flush_decode, 1'b0);
    chk2("rst_pending", pending, 2'd0);

    // Write x5, then a dependent read of x5 directly behind it.
    next_cycle();
    rst = 1'b0; id_valid = 1'b1; id_rd = 5'd5; id_rd_we = 1'b1;
    #1;
    chk1("raw_prod_stall", stall_fetch, 1'b0);
    chk1("raw_prod_bubble", bubble_ex, 1'b0);
    chk2("raw_prod_pending", pending, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
      #1;
      chk1($sformatf("raw_stall_c%0d", k), stall_fetch, 1'b1);
      chk1($sformatf("raw_bubble_c%0d", k), bubble_ex, 1'b1);
      chk2($sformatf("raw_pending_c%0d", k), pending, 2'd1);
      chk1($sformatf("byp_raw_stall_c%0d", k), b_stall_fetch, k < 3);
    end
    next_cycle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    chk1("raw_issue_stall", stall_fetch, 1'b0);
    chk1("raw_issue_bubble", bubble_ex, 1'b0);
    chk2("raw_issue_pending", pending, 2'd0);

    // id_valid=0: bubble, no stall. u_byp issued the read twice, so it has two entries.
    next_cycle();
    #1;
    chk1("idle_stall", stall_fetch, 1'b0);
    chk1("idle_bubble", bubble_ex, 1'b1);
    chk2("idle_pending", pending, 2'd1);
    chk2("byp_idle_pending", b_pending, 2'd2);
    drain(3);

    // Vector write v7 does not block a scalar read of x7.
    next_cycle();
    id_valid = 1'b1; id_vd = 5'd7; id_vd_we = 1'b1;
    next_cycle();
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    #1;
    chk1("v7_vs_x7_stall", stall_fetch, 1'b0);
    chk1("v7_vs_x7_bubble", bubble_ex, 1'b0);
    drain(4);

    // Vector RAW: write v7, read vs2=7 directly behind it.
    next_cycle();
    id_valid = 1'b1; id_vd = 5'd7; id_vd_we = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      id_valid = 1'b1; id_vs2 = 5'd7; id_vs2_used = 1'b1;
      #1;
      chk1($sformatf("vraw_stall_c%0d", k), stall_fetch, 1'b1);
      chk1($sformatf("byp_vraw_stall_c%0d", k), b_stall_fetch, k < 3);
    end
    next_cycle();
    id_valid = 1'b1; id_vs2 = 5'd7; id_vs2_used = 1'b1;
    #1;
    chk1("vraw_issue_stall", stall_fetch, 1'b0);
    drain(4);

    // Scalar write x3 does not block a vector read of v3.
    next_cycle();
    id_valid = 1'b1; id_rd = 5'd3; id_rd_we = 1'b1;
    next_cycle();
    id_valid = 1'b1; id_vs1 = 5'd3; id_vs1_used = 1'b1;
    #1;
    chk1("x3_vs_v3_stall", stall_fetch, 1'b0);
    drain(4);

    // Write x0 then read x0 on both sources: never a hazard.
    next_cycle();
    id_valid = 1'b1; id_rd = 5'd0; id_rd_we = 1'b1;
    next_cycle();
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1; id_rs2 = 5'd0; id_rs2_used = 1'b1;
    #1;
    chk1("x0_stall", stall_fetch, 1'b0);
    chk1("x0_bubble", bubble_ex, 1'b0);
    drain(4);

    // Taken branch at T writing x1 (link); shadow covers T+1 and T+2.
    next_cycle();
    id_valid = 1'b1; id_branch = 1'b1; id_rd = 5'd1; id_rd_we = 1'b1;
    #1;
    chk1("br_T_pc_load", pc_load, 1'b1);
    chk1("br_T_flush", flush_decode, 1'b0);
    chk1("br_T_bubble", bubble_ex, 1'b0);
    next_cycle();
    id_valid = 1'b1; id_branch = 1'b1; id_rd = 5'd2; id_rd_we = 1'b1;
    #1;
    chk1("br_T1_pc_load", pc_load, 1'b0);
    chk1("br_T1_flush", flush_decode, 1'b1);
    chk1("br_T1_bubble", bubble_ex, 1'b1);
    chk1("br_T1_stall", stall_fetch, 1'b0);
    next_cycle();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_used = 1'b1;
    #1;
    chk1("br_T2_flush", flush_decode, 1'b1);
    chk1("br_T2_stall", stall_fetch, 1'b0);
    chk1("br_T2_bubble", bubble_ex, 1'b1);
    chk2("br_T2_pending", pending, 2'd1);
    next_cycle();
    id_valid = 1'b1; id_rs1 = 5'd2; id_rs1_used = 1'b1;
    #1;
    chk1("br_T3_flush", flush_decode, 1'b0);
    chk1("br_T3_stall", stall_fetch, 1'b0);
    chk1("br_T3_bubble", bubble_ex, 1'b0);
    chk2("br_T3_pending", pending, 2'd1);
    drain(4);

    // Reset pulse from idle so the counters restart, then branch hitting MEM.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; id_valid = 1'b1; id_rd = 5'd9; id_rd_we = 1'b1;
    next_cycle();
    id_valid = 1'b1; id_rd = 5'd10; id_rd_we = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      id_valid = 1'b1; id_branch = 1'b1; id_rs1 = 5'd9; id_rs1_used = 1'b1;
      #1;
      chk1($sformatf("brhz_stall_c%0d", k), stall_fetch, 1'b1);
      chk1($sformatf("brhz_pc_load_c%0d", k), pc_load, 1'b0);
    end
    next_cycle();
    id_valid = 1'b1; id_branch = 1'b1; id_rs1 = 5'd9; id_rs1_used = 1'b1;
    #1;
    chk1("brhz_issue_stall", stall_fetch, 1'b0);
    chk1("brhz_issue_pc_load", pc_load, 1'b1);
`ifdef HAZARD_PERF_EN
    chk32("perf_stall_after_br", perf_stall_cnt, 32'd2);
    chk32("perf_flush_before_shadow", perf_flush_cnt, 32'd0);
`endif
    next_cycle();
    #1;
    chk1("brhz_shadow1_flush", flush_decode, 1'b1);
    next_cycle();
    #1;
    chk1("brhz_shadow2_flush", flush_decode, 1'b1);
`ifdef HAZARD_PERF_EN
    chk32("perf_flush_mid", perf_flush_cnt, 32'd1);
`endif
    next_cycle();
    #1;
    chk1("brhz_shadow_end_flush", flush_decode, 1'b0);
`ifdef HAZARD_PERF_EN
    chk32("perf_flush_end", perf_flush_cnt, 32'd2);
`endif
    drain(4);

    // Reset mid-stall: state cleared, dependent then issues against an empty scoreboard.
    next_cycle();
    id_valid = 1'b1; id_rd = 5'd5; id_rd_we = 1'b1;
    next_cycle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    chk1("rststall_pre_stall", stall_fetch, 1'b1);
    next_cycle();
    rst = 1'b1; id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    chk1("rststall_in_rst_stall", stall_fetch, 1'b0);
    chk2("rststall_in_rst_pending", pending, 2'd0);
    next_cycle();
    rst = 1'b0; id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    chk1("rststall_post_stall", stall_fetch, 1'b0);
    chk1("rststall_post_bubble", bubble_ex, 1'b0);
    chk2("rststall_post_pending", pending, 2'd0);
`ifdef HAZARD_PERF_EN
    chk32("perf_stall_cleared", perf_stall_cnt, 32'd0);
    chk32("perf_flush_cleared", perf_flush_cnt, 32'd0);
`endif

    // Reset mid-shadow: shadow cleared, next instruction issues normally.
    next_cycle();
    id_valid = 1'b1; id_branch = 1'b1;
    #1;
    chk1("rstshadow_pc_load", pc_load, 1'b1);
    next_cycle();
    rst = 1'b1; id_valid = 1'b1;
    #1;
    chk1("rstshadow_in_rst_flush", flush_decode, 1'b0);
    next_cycle();
    rst = 1'b0; id_valid = 1'b1; id_rd = 5'd4; id_rd_we = 1'b1;
    #1;
    chk1("rstshadow_post_flush", flush_decode, 1'b0);
    chk1("rstshadow_post_bubble", bubble_ex, 1'b0);
    chk2("rstshadow_post_pending", pending, 2'd0);

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
